// File: rtl/adc_pkg.sv
// Shared constants and FSM state encoding for the ADC decimating capture path.
package adc_pkg;

    localparam int ADC_DATA_W     = 12;
    localparam int ADC_DECIM_LOG2 = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        ACCUM = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Registered-storage FIFO with extra-MSB pointers; dout shows the head entry combinationally.
// Push while full is accepted only when a pop completes in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_din;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_decim_capture.sv
// Samples the AD9226 bus on each falling edge of the divided ADC clock, averages DECIM samples and
// queues the words; o_valid rises 1 cycle after the completing sample, words are dropped and counted when full.
module adc_decim_capture
    import adc_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int DECIM      = 1 << ADC_DECIM_LOG2,
    parameter int DROP_N     = 7,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              i_enable,
    input  logic              i_adc_clk,
    input  logic [DATA_W-1:0] i_adc_data,
    input  logic              i_adc_otr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_otr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [7:0]        o_ovf_cnt,
    output logic              o_busy
);

    localparam int LOG2  = $clog2(DECIM);
    localparam int ACC_W = DATA_W + LOG2;
    localparam logic [LOG2-1:0] GRP_LAST = LOG2'(DECIM - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_hist;
    logic [DATA_W-1:0] r_data;
    logic              r_otr;
    state_t            r_state;
    logic [7:0]        r_drop_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic [LOG2-1:0]   r_grp_cnt;
    logic              r_otr_acc;
    logic [7:0]        r_ovf_cnt;

    logic              w_fall;
    logic [ACC_W-1:0]  w_sum;
    logic              w_push;
    logic [DATA_W:0]   w_push_dat;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W:0]   w_dout;

    // The divided clock is treated as data; the bus is stable for many cycles around its falling edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
            r_data  <= '0;
            r_otr   <= 1'b0;
        end else begin
            r_sync1 <= i_adc_clk;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_data  <= i_adc_data;
            r_otr   <= i_adc_otr;
        end
    end

    assign w_fall     = r_hist & ~r_sync2;
    assign w_sum      = r_acc + ACC_W'(r_data);
    assign w_push     = (r_state == ACCUM) & i_enable & w_fall & (r_grp_cnt == GRP_LAST);
    assign w_push_dat = {r_otr_acc | r_otr, w_sum[ACC_W-1:LOG2]};
    assign w_pop      = o_valid & i_ready;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_drop_cnt <= '0;
            r_acc      <= '0;
            r_grp_cnt  <= '0;
            r_otr_acc  <= 1'b0;
        end else if (!i_enable) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_grp_cnt <= '0;
            r_otr_acc <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_drop_cnt <= 8'(DROP_N);
                    r_acc      <= '0;
                    r_grp_cnt  <= '0;
                    r_otr_acc  <= 1'b0;
                    r_state    <= (DROP_N == 0) ? ACCUM : FLUSH;
                end
                FLUSH: begin
                    if (w_fall) begin
                        r_drop_cnt <= r_drop_cnt - 1'b1;
                        if (r_drop_cnt <= 8'd1) begin
                            r_acc     <= '0;
                            r_grp_cnt <= '0;
                            r_otr_acc <= 1'b0;
                            r_state   <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (w_fall) begin
                        if (r_grp_cnt == GRP_LAST) begin
                            r_acc     <= '0;
                            r_grp_cnt <= '0;
                            r_otr_acc <= 1'b0;
                        end else begin
                            r_acc     <= w_sum;
                            r_grp_cnt <= r_grp_cnt + 1'b1;
                            r_otr_acc <= r_otr_acc | r_otr;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ovf_cnt <= '0;
        end else if (w_push && w_full && !w_pop && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_push  (w_push),
        .i_din   (w_push_dat),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_dout  (w_dout)
    );

    assign o_valid   = ~w_empty;
    assign o_otr     = w_dout[DATA_W];
    assign o_data    = w_dout[DATA_W-1:0];
    assign o_ovf_cnt = r_ovf_cnt;
    assign o_busy    = (r_state != IDLE);

endmodule
